// File: rtl/bvb_sweep.sv
// Multi-image banked vector buffer: sweeps the chunks of one stored image and serves
// per-channel column-id requests through show-ahead FIFOs. Define BVB_SWEEP_SKIP_EN for a demand-driven sweep.
module bvb_sweep #(
    parameter int CH         = 4,
    parameter int ID_BITS    = 10,
    parameter int SPLIT_BITS = 4,
    parameter int VAL_BITS   = 8,
    parameter int IMG_BITS   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              wr_en,
    input  logic [IMG_BITS+SPLIT_BITS-1:0]                    wr_addr,
    input  logic [(2**(ID_BITS-SPLIT_BITS))*VAL_BITS-1:0]     wr_data,
    input  logic [IMG_BITS-1:0]                               image_sel,
    input  logic                                              image_load,
    input  logic [CH*ID_BITS-1:0]                             id,
    input  logic [CH-1:0]                                     id_valid,
    output logic [CH-1:0]                                     id_ready,
    output logic [CH*VAL_BITS-1:0]                            vec,
    output logic [CH-1:0]                                     vec_valid,
    input  logic [CH-1:0]                                     vec_ready,
    output logic                                              busy
);

    localparam int LOC_BITS = ID_BITS - SPLIT_BITS;
    localparam int NB       = 2 ** SPLIT_BITS;
    localparam int CHUNK_W  = (2 ** LOC_BITS) * VAL_BITS;
    localparam int ADDR_W   = IMG_BITS + SPLIT_BITS;
    localparam int RAM_D    = 2 ** ADDR_W;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    // Sweep control
    logic [SPLIT_BITS-1:0] bank_cnt_q;
    logic [SPLIT_BITS-1:0] bank_cnt_d;
    logic [SPLIT_BITS-1:0] bank_next;
    logic [SPLIT_BITS-1:0] bank_q;
    logic [IMG_BITS-1:0]   img_q;
    logic                  rd_valid_q;
    logic [ADDR_W-1:0]     rd_addr;

    // Chunk storage
    logic [CHUNK_W-1:0] ram_q [RAM_D];
    logic [CHUNK_W-1:0] ram_out_q;

    // Per-channel request decode and FIFOs
    logic [SPLIT_BITS-1:0] req_bank [CH];
    logic [LOC_BITS-1:0]   req_loc  [CH];
    logic [VAL_BITS-1:0]   push_val [CH];
    logic [CH-1:0]         not_full;
    logic [CH-1:0]         push;
    logic [CH-1:0]         pop;
    logic [CH-1:0]         nonempty;

    logic [VAL_BITS-1:0]   fifo_mem [CH][FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q   [CH];
    logic [PTR_W-1:0]      rptr_q   [CH];
    logic [CNT_W-1:0]      cnt_q    [CH];

    assign rd_addr = {img_q, bank_cnt_q};

    always_comb begin
        not_full = '0;
        push     = '0;
        pop      = '0;
        nonempty = '0;
        vec      = '0;
        for (int c = 0; c < CH; c++) begin
            req_bank[c] = id[c*ID_BITS + LOC_BITS +: SPLIT_BITS];
            req_loc[c]  = id[c*ID_BITS +: LOC_BITS];
            push_val[c] = ram_out_q[int'(req_loc[c])*VAL_BITS +: VAL_BITS];
            not_full[c] = cnt_q[c] < CNT_W'(FIFO_DEPTH);
            nonempty[c] = cnt_q[c] != '0;
            // Only the chunk currently on the RAM output can serve a request.
            push[c]     = rd_valid_q & id_valid[c] & (req_bank[c] == bank_q) & not_full[c];
            pop[c]      = nonempty[c] & vec_ready[c];
            vec[c*VAL_BITS +: VAL_BITS] = fifo_mem[c][rptr_q[c]];
        end
    end

    assign id_ready  = push;
    assign vec_valid = nonempty;
    assign busy      = (|id_valid) | (|nonempty);

`ifdef BVB_SWEEP_SKIP_EN
    logic [NB-1:0]         want;
    logic                  found;
    logic [SPLIT_BITS-1:0] cand;

    // Cyclic first-match search starting after the current bank and ending on it.
    always_comb begin
        want      = '0;
        found     = 1'b0;
        cand      = '0;
        bank_next = bank_cnt_q;
        for (int c = 0; c < CH; c++) begin
            if (id_valid[c] && not_full[c]) begin
                want[req_bank[c]] = 1'b1;
            end
        end
        for (int i = 1; i <= NB; i++) begin
            cand = bank_cnt_q + SPLIT_BITS'(i);
            if (!found && want[cand]) begin
                bank_next = cand;
                found     = 1'b1;
            end
        end
    end
`else
    always_comb begin
        bank_next = bank_cnt_q + 1'b1;
    end
`endif

    // A write steals the RAM port, so the sweep freezes on the current bank.
    assign bank_cnt_d = wr_en ? bank_cnt_q : bank_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_cnt_q <= '0;
            bank_q     <= '0;
            img_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            bank_cnt_q <= bank_cnt_d;
            bank_q     <= bank_cnt_q;
            rd_valid_q <= ~wr_en;
            if (image_load) begin
                img_q <= image_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[wr_addr] <= wr_data;
        end else begin
            ram_out_q <= ram_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (push[c]) begin
                fifo_mem[c][wptr_q[c]] <= push_val[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end else begin
                if (push[c]) begin
                    wptr_q[c] <= wptr_q[c] + 1'b1;
                end
                if (pop[c]) begin
                    rptr_q[c] <= rptr_q[c] + 1'b1;
                end
                cnt_q[c] <= cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            end
        end
    end

endmodule

// File: tb/tb_bvb_sweep.sv
// Scoreboard bench for bvb_sweep: expected values queued at request time, popped by a monitor.
module tb_bvb_sweep;

    localparam int CH         = 4;
    localparam int ID_BITS    = 10;
    localparam int SPLIT_BITS = 4;
    localparam int VAL_BITS   = 8;
    localparam int IMG_BITS   = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int CHUNK_W    = 512;

    logic                          clk;
    logic                          rst;
    logic                          wr_en;
    logic [IMG_BITS+SPLIT_BITS-1:0] wr_addr;
    logic [CHUNK_W-1:0]            wr_data;
    logic [IMG_BITS-1:0]           image_sel;
    logic                          image_load;
    logic [CH*ID_BITS-1:0]         id;
    logic [CH-1:0]                 id_valid;
    logic [CH-1:0]                 id_ready;
    logic [CH*VAL_BITS-1:0]        vec;
    logic [CH-1:0]                 vec_valid;
    logic [CH-1:0]                 vec_ready;
    logic                          busy;

    bvb_sweep #(
        .CH(CH), .ID_BITS(ID_BITS), .SPLIT_BITS(SPLIT_BITS),
        .VAL_BITS(VAL_BITS), .IMG_BITS(IMG_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .image_sel(image_sel), .image_load(image_load), .id(id), .id_valid(id_valid),
        .id_ready(id_ready), .vec(vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [CH][$];
    logic [7:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int c, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (id_ready[c]) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_bank(input logic [3:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (dut.bank_cnt_q == b) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic write_chunk(input logic [5:0] a, input logic [CHUNK_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Monitor: every handshake on the output side is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                if (vec_valid[c] && vec_ready[c]) begin
                    tests++;
                    if (exp_q[c].size() == 0) begin
                        fails++;
                        $display("FAIL mon_unexpected ch%0d: got %0h, expected nothing", c, vec[c*8 +: 8]);
                    end else begin
                        mon_e = exp_q[c].pop_front();
                        if (vec[c*8 +: 8] !== mon_e) begin
                            fails++;
                            $display("FAIL mon_value ch%0d: got %0h, expected %0h", c, vec[c*8 +: 8], mon_e);
                        end
                    end
                end
            end
        end
    end

    // Protocol guard: id must stay stable while a request is pending.
    logic [CH-1:0]         pend_q  = '0;
    logic [CH*ID_BITS-1:0] id_prev = '0;
    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (pend_q[c] && id_valid[c]) begin
                assert (id[c*ID_BITS +: ID_BITS] == id_prev[c*ID_BITS +: ID_BITS])
                else $error("id changed while pending on ch%0d", c);
            end
        end
        pend_q  <= id_valid & ~id_ready;
        id_prev <= id;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CHUNK_W-1:0] d;
        bit ok;
        bit seen;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        image_sel = '0; image_load = 1'b0; id = '0; id_valid = '0; vec_ready = 4'hF;
        repeat (3) tick();
        check("rst_id_ready", id_ready, 0);
        check("rst_vec_valid", vec_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        check("post_rst_rd_valid", dut.rd_valid_q, 0);
        check("post_rst_id_ready", id_ready, 0);
        tick();

        d = '0; d[5*8 +: 8] = 8'hA5;              write_chunk(6'd3, d);
        for (int k = 0; k < 64; k++) d[k*8 +: 8] = 8'(8'h10 + k);
        write_chunk(6'd0, d);
        d = '0; d[7:0] = 8'h11;                   write_chunk(6'd2, d);
        d = '0; d[7:0] = 8'h22;                   write_chunk(6'd18, d);
        d = '0; d[1*8 +: 8] = 8'h5C;              write_chunk(6'd9, d);

`ifdef BVB_SWEEP_SKIP_EN
        // Demand-driven sweep: only ch2 pending at bank 9.
        rst = 1'b1;
        tick();
        id[29:20] = 10'd577; id_valid[2] = 1'b1; exp_q[2].push_back(8'h5C);
        tick();
        rst = 1'b0;
        check("skip_start_bank", dut.bank_cnt_q, 0);
        tick();
        check("skip_jump_bank", dut.bank_cnt_q, 9);
        check("skip_not_yet", id_ready[2], 0);
        tick();
        check("skip_ready", id_ready[2], 1);
        check("skip_bank_q", dut.bank_q, 9);
        tick();
        id_valid[2] = 1'b0;
        tick(); tick();
        check("skip_idle_hold", dut.bank_cnt_q, 9);
`endif

        // Single request on ch0.
        id[9:0] = 10'd197; id_valid[0] = 1'b1; exp_q[0].push_back(8'hA5);
        wait_ready(0, 40, ok);
        check("t1_accept", ok, 1);
        check("t1_bank_q", dut.bank_q, 3);
        tick();
        check("t1_one_cycle", id_ready[0], 0);
        check("t1_vec_valid", vec_valid[0], 1);
        check("t1_vec", vec[7:0], 8'hA5);
        id_valid = '0;
        tick();

`ifndef BVB_SWEEP_SKIP_EN
        // All channels, same id.
        id = {4{10'd197}}; id_valid = 4'hF;
        for (int c = 0; c < CH; c++) exp_q[c].push_back(8'hA5);
        wait_ready(0, 40, ok);
        check("t2_accept", ok, 1);
        check("t2_all_ready", id_ready, 4'hF);
        tick();
        id_valid = '0;
        check("t2_all_valid", vec_valid, 4'hF);
        tick();

        // Fill ch1 FIFO and hold the ninth request.
        vec_ready = 4'b1101;
        for (int n = 0; n < 8; n++) begin
            id[19:10] = 10'(n); id_valid[1] = 1'b1;
            exp_q[1].push_back(8'(8'h10 + n));
            wait_ready(1, 40, ok);
            check("t3_fill_accept", ok, 1);
            tick();
        end
        id[19:10] = 10'd8; exp_q[1].push_back(8'h18);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (id_ready[1]) seen = 1'b1;
            tick();
        end
        check("t3_full_hold", seen, 0);
        check("t3_full_valid", vec_valid[1], 1);
        vec_ready[1] = 1'b1;
        tick();
        vec_ready[1] = 1'b0;
        wait_ready(1, 17, ok);
        check("t3_retry_accept", ok, 1);
        tick();
        id_valid[1] = 1'b0;
        vec_ready[1] = 1'b1;
        for (int i = 0; i < 20 && vec_valid[1]; i++) tick();
        check("t3_drained", vec_valid[1], 0);

        // Write burst freezes the sweep.
        wait_bank(4'd8, ok);
        check("t4_reach_bank", ok, 1);
        id[9:0] = 10'd197; id_valid[0] = 1'b1; exp_q[0].push_back(8'hA5);
        wr_en = 1'b1; wr_data = '1;
        for (int k = 0; k < 3; k++) begin
            wr_addr = 6'(48 + k);
            tick();
            check("t4_frozen_bank", dut.bank_cnt_q, 8);
            check("t4_no_ready", id_ready, 0);
        end
        wr_en = 1'b0;
        tick();
        check("t4_resume_cnt", dut.bank_cnt_q, 9);
        check("t4_resume_bank_q", dut.bank_q, 8);
        wait_ready(0, 40, ok);
        check("t4_accept", ok, 1);
        tick();
        id_valid[0] = 1'b0;
        tick();

        // Image switch: bank 2 differs between images 0 and 1.
        wait_bank(4'd10, ok);
        check("t5_reach_bank", ok, 1);
        image_sel = 2'd1; image_load = 1'b1;
        tick();
        image_load = 1'b0;
        check("t5_img_q", dut.img_q, 1);
        id[39:30] = 10'd128; id_valid[3] = 1'b1; exp_q[3].push_back(8'h22);
        wait_ready(3, 40, ok);
        check("t5_img1_accept", ok, 1);
        tick();
        id_valid[3] = 1'b0;
        wait_bank(4'd10, ok);
        image_sel = 2'd0; image_load = 1'b1;
        tick();
        image_load = 1'b0;
        id_valid[3] = 1'b1; exp_q[3].push_back(8'h11);
        wait_ready(3, 40, ok);
        check("t5_img0_accept", ok, 1);
        tick();
        id_valid[3] = 1'b0;
        tick();

        // Reset with data stuck in a FIFO.
        vec_ready[2] = 1'b0;
        id[29:20] = 10'd197; id_valid[2] = 1'b1;
        wait_ready(2, 40, ok);
        check("t6_accept", ok, 1);
        tick();
        id_valid[2] = 1'b0;
        check("t6_pre_rst_valid", vec_valid[2], 1);
        rst = 1'b1;
        tick();
        check("t6_rst_vec_valid", vec_valid, 0);
        check("t6_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        vec_ready = 4'hF;
        check("t6_post_rd_valid", dut.rd_valid_q, 0);
        id[9:0] = 10'd197; id_valid[0] = 1'b1; exp_q[0].push_back(8'hA5);
        wait_ready(0, 40, ok);
        check("t6_ram_kept", ok, 1);
        tick();
        id_valid[0] = 1'b0;
`endif

        repeat (4) tick();
        for (int c = 0; c < CH; c++) check("sb_empty", exp_q[c].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
